// File: rtl/anode_if.sv
// Display scan bus between the anode sequencer and its controller.
// The optional duty input exists only when ANODE_DIM_EN is defined.
interface anode_if;
    logic       enable;
    logic [7:0] digit_en;
`ifdef ANODE_DIM_EN
    logic [3:0] duty;
`endif
    logic [2:0] sel;
    logic [7:0] anode;
    logic       tick;

    modport master (
        output enable,
        output digit_en,
`ifdef ANODE_DIM_EN
        output duty,
`endif
        input  sel,
        input  anode,
        input  tick
    );

    modport slave (
        input  enable,
        input  digit_en,
`ifdef ANODE_DIM_EN
        input  duty,
`endif
        output sel,
        output anode,
        output tick
    );
endinterface

// File: rtl/anode_sequencer.sv
// Eight-digit seven-segment scan sequencer with blanking dead-time between digits.
// Define ANODE_DIM_EN to add a 4-bit PWM brightness control (duty input).
module anode_sequencer #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    anode_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_DRIVE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       sel_q,   sel_d;
    logic [7:0]       anode_q, anode_d;
    logic             tick_q,  tick_d;
    logic             lit;

`ifdef ANODE_DIM_EN
    logic [3:0]       pwm_q,   pwm_d;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;

        if (!bus.enable) begin
            // Dropping enable freezes sel so the scan resumes on the same digit.
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        sel_d   = sel_q + 3'd1;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef ANODE_DIM_EN
    // PWM phase restarts at every DRIVE entry so each slot begins lit.
    always_comb begin
        pwm_d = '0;
        if (state_d == ST_DRIVE) begin
            pwm_d = (state_q == ST_DRIVE) ? pwm_q + 4'd1 : 4'd0;
        end
    end

    assign lit = (state_d == ST_DRIVE) && bus.digit_en[sel_d] && (pwm_d < bus.duty);
`else
    assign lit = (state_d == ST_DRIVE) && bus.digit_en[sel_d];
`endif

    // Anode is decoded from next-state values so the registered output matches the state.
    always_comb begin
        anode_d = 8'hFF;
        if (lit) begin
            anode_d = ~(8'b1 << sel_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all ordering lives in always_comb.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            sel_q   <= '0;
            anode_q <= 8'hFF;
            tick_q  <= 1'b0;
`ifdef ANODE_DIM_EN
            pwm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
`ifdef ANODE_DIM_EN
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign bus.sel   = sel_q;
    assign bus.anode = anode_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_anode_sequencer.sv
// Directed bench for anode_sequencer (REFRESH_DIV=10, BLANK_CYC=2).
// With ANODE_DIM_EN defined, a second instance (REFRESH_DIV=34) checks the PWM dimming.
module tb_anode_sequencer;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    anode_if bus ();

    anode_sequencer #(
        .REFRESH_DIV (10),
        .BLANK_CYC   (2)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

`ifdef ANODE_DIM_EN
    logic    rst_dim_n;
    anode_if bus_dim ();

    anode_sequencer #(
        .REFRESH_DIV (34),
        .BLANK_CYC   (2)
    ) u_dim (
        .clk     (clk),
        .reset_n (rst_dim_n),
        .bus     (bus_dim.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] an, input logic [2:0] sl, input logic tk);
        chk({tag, " anode"}, bus.anode, an);
        chk({tag, " sel"}, {5'd0, bus.sel}, {5'd0, sl});
        chk({tag, " tick"}, {7'd0, bus.tick}, {7'd0, tk});
    endtask

    // One full 10-cycle slot: 2 blanking cycles, then 8 lit (or dark when masked).
    task automatic check_slot(input int s, input bit on, input bit tk);
        logic [7:0] code;
        logic [7:0] exp_an;
        code = on ? ~(8'b1 << s) : 8'hFF;
        for (int c = 0; c < 10; c++) begin
            step();
            exp_an = (c < 2) ? 8'hFF : code;
            chk_all($sformatf("slot%0d c%0d", s, c), exp_an, 3'(s), (c == 0) ? tk : 1'b0);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.digit_en  = 8'hFF;
`ifdef ANODE_DIM_EN
        bus.duty      = 4'd15;
        rst_dim_n     = 1'b0;
        bus_dim.enable   = 1'b1;
        bus_dim.digit_en = 8'hFF;
        bus_dim.duty     = 4'd8;
`endif

        // Reset held with enable high.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("reset%0d", i), 8'hFF, 3'd0, 1'b0);
        end
        reset_n = 1'b1;

        // Normal scan: full frame then wrap back to digit 0.
        check_slot(0, 1'b1, 1'b0);
        for (int s = 1; s < 8; s++) begin
            check_slot(s, 1'b1, 1'b1);
        end
        check_slot(0, 1'b1, 1'b1);

        // Digit 2 masked off: slot still consumed and still ticks.
        bus.digit_en = 8'hFB;
        check_slot(1, 1'b1, 1'b1);
        check_slot(2, 1'b0, 1'b1);
        check_slot(3, 1'b1, 1'b1);
        bus.digit_en = 8'hFF;
        check_slot(4, 1'b1, 1'b1);

        // Enable dropped in the 4th DRIVE cycle of digit 5.
        step(); chk_all("en5 b0", 8'hFF, 3'd5, 1'b1);
        step(); chk_all("en5 b1", 8'hFF, 3'd5, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk_all($sformatf("en5 d%0d", c), 8'hDF, 3'd5, 1'b0);
        end
        bus.enable = 1'b0;
        step(); chk_all("en5 off0", 8'hFF, 3'd5, 1'b0);
        step(); chk_all("en5 off1", 8'hFF, 3'd5, 1'b0);
        bus.enable = 1'b1;
        check_slot(5, 1'b1, 1'b0);

        // Reset in the middle of digit 6 DRIVE.
        step(); chk_all("rst6 b0", 8'hFF, 3'd6, 1'b1);
        step(); chk_all("rst6 b1", 8'hFF, 3'd6, 1'b0);
        step(); chk_all("rst6 d0", 8'hBF, 3'd6, 1'b0);
        reset_n = 1'b0;
        step(); chk_all("rst6 hit", 8'hFF, 3'd0, 1'b0);
        reset_n = 1'b1;
        check_slot(0, 1'b1, 1'b0);

`ifdef ANODE_DIM_EN
        // Dimming: 32 DRIVE cycles, lit for pwm 0..7 of each 16-cycle period.
        rst_dim_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            step();
            chk($sformatf("dim8 c%0d", c), bus_dim.anode,
                (c >= 2 && ((c - 2) % 16) < 8) ? 8'hFE : 8'hFF);
        end
        bus_dim.duty = 4'd0;
        for (int c = 0; c < 34; c++) begin
            step();
            chk($sformatf("dim0 c%0d", c), bus_dim.anode, 8'hFF);
        end
        chk("dim0 sel", {5'd0, bus_dim.sel}, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
